wrr_scheduling_kernel: RTL and testbench

- Weighted round-robin successor of the RR scheduling kernel.
- Arbitrates NCONSUMERS request streams onto NBANKS x NPORTS PLM kernel ports, with low-order address interleaving across banks.
- Adds per-consumer grant handshake (back-pressure), programmable per-consumer burst weights, registered outputs with a valid strobe, and saturating per-consumer grant counters.
- Sits between the accelerator consumers and the banked PLM.

---
 rtl/wrr_scheduling_kernel.sv | 157 +++++++++++++++
 tb/tb_wrr_scheduling_kernel.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wrr_scheduling_kernel.sv
`default_nettype none
// ============================================================================
// Module   : wrr_scheduling_kernel
// Brief    : Weighted round-robin arbiter mapping NCONSUMERS request streams
//            onto NBANKS x NPORTS PLM kernel ports with low-order address
//            interleaving, grant handshake, registered outputs and saturating
//            per-consumer grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module wrr_scheduling_kernel #(
    parameter int ADDR_WIDTH    = 4,
    parameter int VALUE_WIDTH   = 8,
    parameter int NCONSUMERS    = 2,
    parameter int NBANKS        = 1,
    parameter int NPORTS        = 2,
    parameter int WEIGHT_WIDTH  = 4,
    parameter int COUNTER_WIDTH = 8,
    parameter int BANK_BITS       = $clog2(NBANKS),
    parameter int REQ_WIDTH       = ADDR_WIDTH + VALUE_WIDTH + 2,
    parameter int PLM_INPUT_WIDTH = ADDR_WIDTH - BANK_BITS + VALUE_WIDTH + 1,
    parameter int NKERNELS        = NBANKS * NPORTS
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NCONSUMERS*REQ_WIDTH-1:0]       requests,
    input  logic [NCONSUMERS*WEIGHT_WIDTH-1:0]    weights,
    output logic [NCONSUMERS-1:0]                 grant,
    output logic [NKERNELS*PLM_INPUT_WIDTH-1:0]   out,
    output logic [NKERNELS-1:0]                   out_valid,
    output logic [NCONSUMERS*COUNTER_WIDTH-1:0]   grant_count
);

    localparam int PTR_W   = $clog2(NCONSUMERS);
    localparam int BANK_W  = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int LADDR_W = ADDR_WIDTH - BANK_BITS;

    // Per-consumer decoded request fields
    logic [NCONSUMERS-1:0]       req_valid;
    logic [BANK_W-1:0]           req_bank [NCONSUMERS];
    logic [PLM_INPUT_WIDTH-1:0]  req_data [NCONSUMERS];

    // Per-bank arbitration state
    logic [PTR_W-1:0]            ptr       [NBANKS];
    logic [WEIGHT_WIDTH-1:0]     remaining [NBANKS];
    logic [PTR_W-1:0]            nxt_ptr   [NBANKS];
    logic [WEIGHT_WIDTH-1:0]     nxt_rem   [NBANKS];

    logic [NCONSUMERS-1:0]               sel;
    logic [NKERNELS*PLM_INPUT_WIDTH-1:0] kdata;
    logic [NKERNELS-1:0]                 kvalid;

    generate
        for (genvar gc = 0; gc < NCONSUMERS; gc++) begin : g_dec
            logic [REQ_WIDTH-1:0]  req;
            logic [ADDR_WIDTH-1:0] addr;
            assign req            = requests[gc*REQ_WIDTH +: REQ_WIDTH];
            assign addr           = req[VALUE_WIDTH +: ADDR_WIDTH];
            assign req_valid[gc]  = req[REQ_WIDTH-1];
            // Single-bank configurations route everything to bank 0
            assign req_bank[gc]   = (NBANKS == 1) ? '0 : addr[BANK_W-1:0];
            assign req_data[gc]   = {req[REQ_WIDTH-2],
                                     addr[ADDR_WIDTH-1 -: LADDR_W],
                                     req[VALUE_WIDTH-1:0]};
        end
    endgenerate

    // Grants are suppressed while reset is asserted
    assign grant = sel & {NCONSUMERS{reset_n}};

    // Scan each bank from its pointer, allocate ports, and compute next pointer/burst state
    always_comb begin
        int                      c;
        int                      cnt;
        logic                    any;
        logic                    ptr_hit;
        logic [PTR_W-1:0]        last;
        logic [WEIGHT_WIDTH-1:0] w;
        logic [WEIGHT_WIDTH-1:0] eff;
        sel     = '0;
        kdata   = out;
        kvalid  = '0;
        c       = 0;
        cnt     = 0;
        any     = 1'b0;
        ptr_hit = 1'b0;
        last    = '0;
        w       = '0;
        eff     = '0;
        for (int b = 0; b < NBANKS; b++) begin
            cnt     = 0;
            any     = 1'b0;
            ptr_hit = 1'b0;
            last    = '0;
            for (int i = 0; i < NCONSUMERS; i++) begin
                c = int'(ptr[b]) + i;
                if (c >= NCONSUMERS) c = c - NCONSUMERS;
                if (req_valid[c] && (int'(req_bank[c]) == b) && (cnt < NPORTS)) begin
                    sel[c] = 1'b1;
                    kvalid[b*NPORTS + cnt] = 1'b1;
                    kdata[(b*NPORTS + cnt)*PLM_INPUT_WIDTH +: PLM_INPUT_WIDTH] = req_data[c];
                    last = PTR_W'(c);
                    any  = 1'b1;
                    if (i == 0) ptr_hit = 1'b1;
                    cnt = cnt + 1;
                end
            end
            // Burst bookkeeping: weights only sampled when a new burst starts
            w   = weights[int'(ptr[b])*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            eff = (remaining[b] != '0) ? remaining[b] :
                  ((w == '0) ? WEIGHT_WIDTH'(1) : w);
            nxt_ptr[b] = ptr[b];
            nxt_rem[b] = remaining[b];
            if (any) begin
                if (ptr_hit && (eff > WEIGHT_WIDTH'(1))) begin
                    nxt_rem[b] = eff - 1'b1;
                end else begin
                    nxt_rem[b] = '0;
                    nxt_ptr[b] = (int'(last) == NCONSUMERS - 1) ? '0 : last + 1'b1;
                end
            end
        end
    end

    // Arbitration state and registered kernel outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= '0;
            for (int b = 0; b < NBANKS; b++) begin
                ptr[b]       <= '0;
                remaining[b] <= '0;
            end
        end else begin
            out       <= kdata;
            out_valid <= kvalid;
            for (int b = 0; b < NBANKS; b++) begin
                ptr[b]       <= nxt_ptr[b];
                remaining[b] <= nxt_rem[b];
            end
        end
    end

    // Saturating per-consumer grant counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_count <= '0;
        end else begin
            for (int c = 0; c < NCONSUMERS; c++) begin
                if (grant[c] && (grant_count[c*COUNTER_WIDTH +: COUNTER_WIDTH] != {COUNTER_WIDTH{1'b1}}))
                    grant_count[c*COUNTER_WIDTH +: COUNTER_WIDTH] <=
                        grant_count[c*COUNTER_WIDTH +: COUNTER_WIDTH] + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wrr_scheduling_kernel.sv
`default_nettype none
// ============================================================================
// Module   : tb_wrr_scheduling_kernel
// Brief    : Directed scoreboard bench for wrr_scheduling_kernel; a 2-bank
//            single-port instance and a 1-bank dual-port 3-consumer instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wrr_scheduling_kernel;

    logic        clk = 1'b0;
    logic        reset_n;

    // Main instance: NBANKS=2, NPORTS=1, NCONSUMERS=2
    logic [27:0] requests;
    logic [7:0]  weights;
    logic [1:0]  grant;
    logic [23:0] out;
    logic [1:0]  out_valid;
    logic [15:0] grant_count;

    // Multiport instance: NBANKS=1, NPORTS=2, NCONSUMERS=3
    logic [41:0] requests_m;
    logic [11:0] weights_m;
    logic [2:0]  grant_m;
    logic [25:0] out_m;
    logic [1:0]  out_valid_m;
    logic [23:0] grant_count_m;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  v;
        logic [25:0] d;
    } exp_t;

    exp_t        sbq [$];
    exp_t        e;
    logic [23:0] exp_out;
    logic [7:0]  mc [2];

    always #5 clk = ~clk;

    wrr_scheduling_kernel #(
        .ADDR_WIDTH(4), .VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(2), .NPORTS(1),
        .WEIGHT_WIDTH(4), .COUNTER_WIDTH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .requests(requests), .weights(weights),
        .grant(grant), .out(out), .out_valid(out_valid), .grant_count(grant_count)
    );

    wrr_scheduling_kernel #(
        .ADDR_WIDTH(4), .VALUE_WIDTH(8), .NCONSUMERS(3), .NBANKS(1), .NPORTS(2),
        .WEIGHT_WIDTH(4), .COUNTER_WIDTH(8)
    ) dut_m (
        .clk(clk), .reset_n(reset_n), .requests(requests_m), .weights(weights_m),
        .grant(grant_m), .out(out_m), .out_valid(out_valid_m), .grant_count(grant_count_m)
    );

    function automatic logic [13:0] rq(input logic v, input logic we,
                                       input logic [3:0] a, input logic [7:0] d);
        return {v, we, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle on the main instance: drive, check grant, push expected, clock, compare outputs
    task automatic step(input logic [13:0] r0, input logic [13:0] r1,
                        input logic [1:0] eg, input string tag);
        logic [13:0] r;
        logic [1:0]  v;
        requests = {r1, r0};
        #1;
        chk({tag, "/grant"}, {30'd0, grant}, {30'd0, eg});
        v = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (eg[c]) begin
                r = (c == 0) ? r0 : r1;
                exp_out[int'(r[8])*12 +: 12] = {r[12], r[11:9], r[7:0]};
                v[r[8]] = 1'b1;
                if (mc[c] != 8'hFF) mc[c] = mc[c] + 8'd1;
            end
        end
        sbq.push_back('{v: v, d: {2'b00, exp_out}});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, "/out_valid"}, {30'd0, out_valid}, {30'd0, e.v});
        chk({tag, "/out"}, {8'd0, out}, {8'd0, e.d[23:0]});
        chk({tag, "/count"}, {16'd0, grant_count}, {16'd0, mc[1], mc[0]});
    endtask

    // One cycle on the multiport instance with constant expectations
    task automatic step_m(input logic [2:0] eg, input logic [25:0] eo, input string tag);
        #1;
        chk({tag, "/grant"}, {29'd0, grant_m}, {29'd0, eg});
        sbq.push_back('{v: 2'b11, d: eo});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, "/out_valid"}, {30'd0, out_valid_m}, {30'd0, e.v});
        chk({tag, "/out"}, {6'd0, out_m}, {6'd0, e.d});
    endtask

    logic [13:0] a0, b0, idle;

    initial begin
        idle       = 14'd0;
        a0         = rq(1'b1, 1'b0, 4'h0, 8'h11);
        b0         = rq(1'b1, 1'b0, 4'h2, 8'h22);
        reset_n    = 1'b0;
        weights    = 8'h11;
        requests   = {b0, a0};
        requests_m = 42'd0;
        weights_m  = 12'h111;
        exp_out    = 24'd0;
        mc[0]      = 8'd0;
        mc[1]      = 8'd0;

        // Reset with both consumers requesting
        repeat (2) @(posedge clk);
        #1;
        chk("rst/grant", {30'd0, grant}, 32'd0);
        chk("rst/out", {8'd0, out}, 32'd0);
        chk("rst/out_valid", {30'd0, out_valid}, 32'd0);
        chk("rst/count", {16'd0, grant_count}, 32'd0);
        chk("rst/grant_m", {29'd0, grant_m}, 32'd0);
        reset_n = 1'b1;

        // Fairness, weights 1/1
        step(a0, b0, 2'b01, "rr1_0");
        step(a0, b0, 2'b10, "rr1_1");
        step(a0, b0, 2'b01, "rr1_2");
        step(a0, b0, 2'b10, "rr1_3");

        // Single write to bank 1
        step(rq(1'b1, 1'b1, 4'h5, 8'hA5), idle, 2'b01, "single");

        // Weights 3/1
        weights = 8'h13;
        for (int i = 0; i < 8; i++)
            step(a0, b0, ((i % 4) == 3) ? 2'b10 : 2'b01, $sformatf("w31_%0d", i));

        // Weight 0 behaves as 1
        weights = 8'h00;
        for (int i = 0; i < 4; i++)
            step(a0, b0, (i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("w00_%0d", i));

        // Parallel banks and an idle cycle
        weights = 8'h11;
        step(rq(1'b1, 1'b0, 4'h2, 8'h33), rq(1'b1, 1'b1, 4'h3, 8'h44), 2'b11, "parallel");
        step(idle, idle, 2'b00, "idle");

        // Saturation of consumer 0's counter
        for (int i = 0; i < 300; i++)
            step(a0, idle, 2'b01, "sat");
        chk("sat/final", {24'd0, grant_count[7:0]}, 32'h0000_00FF);

        // Burst on consumer 1 aborted by asynchronous reset
        weights = 8'h31;
        step(a0, b0, 2'b10, "abort_pre");
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort/grant", {30'd0, grant}, 32'd0);
        chk("abort/count", {16'd0, grant_count}, 32'd0);
        chk("abort/out_valid", {30'd0, out_valid}, 32'd0);
        chk("abort/out", {8'd0, out}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_out = 24'd0;
        mc[0]   = 8'd0;
        mc[1]   = 8'd0;
        step(a0, b0, 2'b01, "post_rst_0");
        step(a0, b0, 2'b10, "post_rst_1");
        step(a0, b0, 2'b10, "post_rst_2");

        // Multiport: three consumers, two ports on one bank
        requests = 28'd0;
        requests_m = {rq(1'b1, 1'b0, 4'h2, 8'h12), rq(1'b1, 1'b0, 4'h1, 8'h11),
                      rq(1'b1, 1'b0, 4'h0, 8'h10)};
        step_m(3'b011, {13'h0111, 13'h0010}, "mp_0");
        step_m(3'b101, {13'h0010, 13'h0212}, "mp_1");
        step_m(3'b110, {13'h0212, 13'h0111}, "mp_2");
        chk("mp/count", {8'd0, grant_count_m}, {8'd0, 8'd2, 8'd2, 8'd2});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
